// File: rtl/pipeline_pkg.sv
// Shared opcode/func constants and sequencer state encoding for the
// five-stage pipeline hazard and sequencing controller.
package pipeline_pkg;

    localparam logic [5:0] OP_ALUOP = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

endpackage

// File: rtl/reg_use_decode.sv
// Decodes which registers an instruction writes and which of its rs/rt
// fields it actually reads; 32'h0 (bubble) uses nothing.
module reg_use_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [4:0]  dest_o,
    output logic        dest_valid_o,
    output logic        rs_used_o,
    output logic        rt_used_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op           = inst_i[31:26];
    assign fn           = inst_i[5:0];
    assign rt           = inst_i[20:16];
    assign rd           = inst_i[15:11];
    assign unused_shamt = ^inst_i[10:6];

    always_comb begin
        dest_o       = 5'd0;
        dest_valid_o = 1'b0;
        rs_used_o    = 1'b0;
        rt_used_o    = 1'b0;
        if (inst_i != 32'h0) begin
            case (op)
                OP_ALUOP: begin
                    dest_o    = rd;
                    rt_used_o = 1'b1;
                    rs_used_o = !(fn == FN_SLL || fn == FN_SRL || fn == FN_SRA);
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                    dest_o    = rt;
                    rs_used_o = 1'b1;
                end
                OP_SW, OP_BEQ: begin
                    rs_used_o = 1'b1;
                    rt_used_o = 1'b1;
                end
                default: ;
            endcase
        end
        // $0 is hardwired, so writing it never creates a dependence
        dest_valid_o = (dest_o != 5'd0);
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// RAW stall, branch flush and debug halt/drain sequencing for a
// forwarding-free five-stage pipeline, plus wrapping perf counters.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [31:0]      ifid_inst_i,
    input  logic [31:0]      idex_inst_i,
    input  logic [31:0]      exmem_inst_i,
    input  logic [31:0]      memwb_inst_i,
    input  logic             branch_taken_i,
    input  logic             halt_req_i,
    output logic             halt_ack_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] retired_cnt_o
);

    seq_state_e state_q, state_d;
    logic             halt_ack_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    logic       ifid_rs_used, ifid_rt_used;
    logic [4:0] unused_ifid_dest;
    logic       unused_ifid_dest_valid;
    logic [4:0] dest [3];
    logic [2:0] dest_valid;
    logic [2:0] unused_rs_used, unused_rt_used;
    logic       raw, pipe_empty, stall_inc;

    reg_use_decode u_dec_ifid (
        .inst_i(ifid_inst_i), .dest_o(unused_ifid_dest), .dest_valid_o(unused_ifid_dest_valid),
        .rs_used_o(ifid_rs_used), .rt_used_o(ifid_rt_used)
    );
    reg_use_decode u_dec_idex (
        .inst_i(idex_inst_i), .dest_o(dest[0]), .dest_valid_o(dest_valid[0]),
        .rs_used_o(unused_rs_used[0]), .rt_used_o(unused_rt_used[0])
    );
    reg_use_decode u_dec_exmem (
        .inst_i(exmem_inst_i), .dest_o(dest[1]), .dest_valid_o(dest_valid[1]),
        .rs_used_o(unused_rs_used[1]), .rt_used_o(unused_rt_used[1])
    );
    reg_use_decode u_dec_memwb (
        .inst_i(memwb_inst_i), .dest_o(dest[2]), .dest_valid_o(dest_valid[2]),
        .rs_used_o(unused_rs_used[2]), .rt_used_o(unused_rt_used[2])
    );

    // MEM/WB producer still conflicts: the register file writes at the end of WB
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (dest_valid[k] &&
                ((ifid_rs_used && ifid_inst_i[25:21] == dest[k]) ||
                 (ifid_rt_used && ifid_inst_i[20:16] == dest[k]))) begin
                raw = 1'b1;
            end
        end
    end

    assign pipe_empty = (idex_inst_i == 32'h0) && (exmem_inst_i == 32'h0) &&
                        (memwb_inst_i == 32'h0);
    assign stall_inc  = raw && !branch_taken_i &&
                        (state_q == ST_RUN || state_q == ST_STALL);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_RUN;
            halt_ack_q    <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            halt_ack_q    <= (state_q == ST_HALTED);
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req_i)                    state_d = ST_DRAIN;
                else if (raw && !branch_taken_i)   state_d = ST_STALL;
            end
            ST_STALL: begin
                if (halt_req_i)                    state_d = ST_DRAIN;
                else if (branch_taken_i || !raw)   state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!halt_req_i)                   state_d = ST_RUN;
                else if (pipe_empty)               state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (!halt_req_i)                   state_d = ST_RUN;
            end
            default:                               state_d = ST_RUN;
        endcase
    end

    // A taken branch overrides every hold so the PC can take the target
    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_flush_o = 1'b0;
        if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (state_q == ST_DRAIN || state_q == ST_HALTED || raw) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d   = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_inc};
        flush_cnt_d   = flush_cnt_q + {{(CNT_W-1){1'b0}}, branch_taken_i};
        retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, (memwb_inst_i != 32'h0)};
    end

    assign state_o       = state_q;
    assign halt_ack_o    = halt_ack_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: a behavioural pipeline/program model drives
// the four stage registers and predicts every control output and counter.
module tb_pipeline_sequencer;

  localparam int CW = 4;
  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000, T_ANDI = 6'b001100, T_ORI = 6'b001101;
  localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2, M_HALTED = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] ifid_r, idex_r, exmem_r, memwb_r;
  logic take_br, halt_req, bt;
  logic halt_ack, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0] state;
  logic [CW-1:0] stall_cnt, flush_cnt, retired_cnt;
  logic [4:0] ctrl;

  assign bt   = (exmem_r[31:26] == T_BEQ) && take_br;
  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush};

  pipeline_sequencer #(.CNT_W(CW)) dut (
    .clock_i(clk), .reset_i(rst),
    .ifid_inst_i(ifid_r), .idex_inst_i(idex_r), .exmem_inst_i(exmem_r), .memwb_inst_i(memwb_r),
    .branch_taken_i(bt), .halt_req_i(halt_req), .halt_ack_o(halt_ack),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .exmem_flush_o(exmem_flush), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .retired_cnt_o(retired_cnt)
  );

  logic [31:0] prog [0:255];
  int pc, br_target;
  int ref_mode, ref_stall, ref_flush, ref_retire;
  bit ref_ack;
  int n_checks = 0, n_pass = 0;

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
    return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int dest_of(logic [31:0] i);
    logic [5:0] op = i[31:26];
    if (op == 6'b0) return (i[15:11] == 5'd0) ? -1 : int'(i[15:11]);
    if (op inside {T_ADDI, T_ANDI, T_ORI, T_LW}) return (i[20:16] == 5'd0) ? -1 : int'(i[20:16]);
    return -1;
  endfunction

  function automatic bit reads(logic [31:0] i, int r);
    int rs = int'(i[25:21]);
    int rt = int'(i[20:16]);
    logic [5:0] op = i[31:26];
    if (op == 6'b0) begin
      if (i[5:0] inside {6'b000000, 6'b000010, 6'b000011}) return rt == r;
      return rs == r || rt == r;
    end
    if (op inside {T_ADDI, T_ANDI, T_ORI, T_LW}) return rs == r;
    if (op inside {T_SW, T_BEQ}) return rs == r || rt == r;
    return 1'b0;
  endfunction

  function automatic bit ref_raw();
    int d [3];
    d[0] = dest_of(idex_r);
    d[1] = dest_of(exmem_r);
    d[2] = dest_of(memwb_r);
    foreach (d[k]) if (d[k] > 0 && reads(ifid_r, d[k])) return 1'b1;
    return 1'b0;
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush}
  function automatic logic [4:0] exp_ctrl();
    if (bt) return 5'b11111;
    if (ref_mode >= M_DRAIN || ref_raw()) return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic logic [31:0] rand_inst();
    int k = $urandom_range(0, 8);
    int a = $urandom_range(0, 7);
    int b = $urandom_range(0, 7);
    int c = $urandom_range(0, 7);
    case (k)
      0: return r_ins(a, b, c, 0, 6'b100000);
      1: return r_ins(a, b, c, 0, 6'b100010);
      2: return r_ins(a, b, c, 2, 6'b000010);
      3: return i_ins(T_ADDI, a, b, 5);
      4: return i_ins(T_LW, a, b, 4);
      5: return i_ins(T_SW, a, b, 8);
      6: return i_ins(T_BEQ, a, b, 3);
      7: return i_ins(T_ORI, a, b, 1);
      default: return 32'h0;
    endcase
  endfunction

  task automatic restart();
    rst = 1'b1;
    halt_req = 1'b0;
    take_br = 1'b0;
    ifid_r = '0; idex_r = '0; exmem_r = '0; memwb_r = '0;
    pc = 0; br_target = 0;
    ref_mode = M_RUN; ref_ack = 1'b0;
    ref_stall = 0; ref_flush = 0; ref_retire = 0;
    for (int k = 0; k < 256; k++) prog[k] = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: predict from pre-edge inputs, then advance the pipeline model
  task automatic step();
    logic [4:0] c;
    bit r, b, h, empty;
    int nm;
    @(posedge clk);
    c = exp_ctrl();
    r = ref_raw();
    b = bt;
    h = halt_req;
    empty = (idex_r == 0) && (exmem_r == 0) && (memwb_r == 0);
    nm = ref_mode;
    case (ref_mode)
      M_RUN:   if (h) nm = M_DRAIN; else if (r && !b) nm = M_STALL;
      M_STALL: if (h) nm = M_DRAIN; else if (b || !r) nm = M_RUN;
      M_DRAIN: if (!h) nm = M_RUN; else if (empty) nm = M_HALTED;
      default: if (!h) nm = M_RUN;
    endcase
    #1;
    ref_ack = (ref_mode == M_HALTED);
    if (r && !b && ref_mode < M_DRAIN) ref_stall++;
    if (b) ref_flush++;
    if (memwb_r != 0) ref_retire++;
    ref_mode = nm;
    memwb_r = exmem_r;
    exmem_r = c[0] ? 32'h0 : idex_r;
    idex_r  = c[1] ? 32'h0 : ifid_r;
    if (c[2]) begin
      ifid_r = 32'h0;
      pc = br_target;
    end else if (c[3]) begin
      ifid_r = prog[pc % 256];
      pc++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 2'd0 || halt_ack !== 1'b0) $display("FAIL reset_state: state=%0d ack=%0b required state=0 ack=0", state, halt_ack);
    else n_pass++;
    restart();
    n_checks++;
    if ({stall_cnt, flush_cnt, retired_cnt} !== '0) $display("FAIL reset_counters: %0d %0d %0d required 0 0 0", stall_cnt, flush_cnt, retired_cnt);
    else n_pass++;
    n_checks++;
    if (ctrl !== 5'b11000) $display("FAIL reset_ctrl: got %b required 11000", ctrl);
    else n_pass++;
  endtask

  task automatic test_adjacent_raw();
    int stalls = 0, bubbles = 0;
    restart();
    prog[0] = r_ins(2, 3, 1, 0, 6'b100000);
    prog[1] = r_ins(1, 5, 4, 0, 6'b100000);
    for (int k = 0; k < 9; k++) begin
      step();
      if (pc_write === 1'b0) stalls++;
      if (idex_bubble === 1'b1) bubbles++;
    end
    n_checks++;
    if (stalls !== 3 || bubbles !== 3) $display("FAIL adjacent_raw_cycles: stalls=%0d bubbles=%0d required 3 3", stalls, bubbles);
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 4'd3) $display("FAIL adjacent_raw_stall_cnt: got %0d required 3", stall_cnt);
    else n_pass++;
    n_checks++;
    if (state !== 2'd0) $display("FAIL adjacent_raw_state: got %0d required 0", state);
    else n_pass++;
    n_checks++;
    if (retired_cnt !== 4'd2) $display("FAIL adjacent_raw_retired: got %0d required 2", retired_cnt);
    else n_pass++;
  endtask

  task automatic test_zero_and_shift();
    int stalls = 0;
    restart();
    prog[0] = i_ins(T_ORI, 0, 0, 5);
    prog[1] = r_ins(0, 0, 6, 0, 6'b100000);
    prog[2] = i_ins(T_ADDI, 0, 7, 1);
    prog[3] = r_ins(7, 9, 8, 2, 6'b000000);
    for (int k = 0; k < 9; k++) begin
      step();
      if (pc_write === 1'b0) stalls++;
    end
    n_checks++;
    if (stalls !== 0 || stall_cnt !== 4'd0) $display("FAIL zero_shift_nostall: stalls=%0d cnt=%0d required 0 0", stalls, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_taken_branch();
    restart();
    prog[0] = i_ins(T_BEQ, 1, 2, 16);
    prog[1] = i_ins(T_ADDI, 0, 10, 1);
    prog[2] = i_ins(T_ADDI, 0, 11, 1);
    prog[3] = i_ins(T_ADDI, 0, 12, 1);
    prog[20] = i_ins(T_ORI, 0, 13, 7);
    br_target = 20;
    repeat (3) step();
    take_br = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 5'b11111) $display("FAIL branch_ctrl: got %b required 11111", ctrl);
    else n_pass++;
    step();
    n_checks++;
    if (flush_cnt !== 4'd1 || ctrl !== 5'b11000) $display("FAIL branch_after: flush_cnt=%0d ctrl=%b required 1 11000", flush_cnt, ctrl);
    else n_pass++;
    step();
    n_checks++;
    if (ifid_r !== prog[20] || pc_write !== 1'b1 || flush_cnt !== 4'd1) $display("FAIL branch_target: ifid=%h pc_write=%0b flush_cnt=%0d required %h 1 1", ifid_r, pc_write, flush_cnt, prog[20]);
    else n_pass++;
    take_br = 1'b0;
  endtask

  task automatic test_halt_drain();
    int drains = 0;
    bit halted = 1'b0;
    restart();
    prog[0] = i_ins(T_LW, 2, 1, 0);
    prog[1] = r_ins(1, 4, 3, 0, 6'b100000);
    repeat (2) step();
    halt_req = 1'b1;
    for (int k = 0; k < 12 && !halted; k++) begin
      step();
      if (state === 2'd2) drains++;
      if (state === 2'd3) halted = 1'b1;
    end
    n_checks++;
    if (!halted || drains !== 3) $display("FAIL halt_drain: halted=%0b drain_cycles=%0d required 1 3", halted, drains);
    else n_pass++;
    step();
    n_checks++;
    if (halt_ack !== 1'b1 || ifid_write !== 1'b0 || pc_write !== 1'b0) $display("FAIL halt_ack: ack=%0b ifid_write=%0b pc_write=%0b required 1 0 0", halt_ack, ifid_write, pc_write);
    else n_pass++;
    halt_req = 1'b0;
    #1;
    step();
    n_checks++;
    if (state !== 2'd0 || pc_write !== 1'b1) $display("FAIL halt_release: state=%0d pc_write=%0b required 0 1", state, pc_write);
    else n_pass++;
    repeat (6) step();
    n_checks++;
    if (retired_cnt !== 4'd2 || halt_ack !== 1'b0) $display("FAIL halt_resume: retired=%0d ack=%0b required 2 0", retired_cnt, halt_ack);
    else n_pass++;
  endtask

  task automatic test_reset_during_stall();
    restart();
    prog[0] = r_ins(2, 3, 1, 0, 6'b100000);
    prog[1] = r_ins(1, 5, 4, 0, 6'b100000);
    repeat (3) step();
    n_checks++;
    if (state !== 2'd1 || stall_cnt !== 4'd1) $display("FAIL pre_reset_stall: state=%0d stall_cnt=%0d required 1 1", state, stall_cnt);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 2'd0 || stall_cnt !== 4'd0 || retired_cnt !== 4'd0) $display("FAIL async_reset: state=%0d stall_cnt=%0d retired=%0d required 0 0 0", state, stall_cnt, retired_cnt);
    else n_pass++;
    restart();
  endtask

  task automatic test_retire_wrap();
    restart();
    for (int k = 0; k < 16; k++) prog[k] = i_ins(T_ADDI, 0, (k % 7) + 1, k);
    repeat (14) step();
    n_checks++;
    if (retired_cnt !== 4'd10) $display("FAIL retired_10: got %0d required 10", retired_cnt);
    else n_pass++;
    repeat (6) step();
    n_checks++;
    if (retired_cnt !== 4'd0) $display("FAIL retired_wrap: got %0d required 0", retired_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [CW-1:0] es, ef, er;
    restart();
    for (int k = 0; k < 256; k++) prog[k] = rand_inst();
    for (int n = 0; n < 600; n++) begin
      take_br = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
      br_target = $urandom_range(0, 255);
      #1;
      n_checks++;
      if (ctrl !== exp_ctrl()) $display("FAIL rand_ctrl cyc %0d: got %b required %b", n, ctrl, exp_ctrl());
      else n_pass++;
      step();
      es = ref_stall[CW-1:0];
      ef = ref_flush[CW-1:0];
      er = ref_retire[CW-1:0];
      n_checks++;
      if (state !== 2'(ref_mode) || halt_ack !== ref_ack) $display("FAIL rand_state cyc %0d: state=%0d ack=%0b required %0d %0b", n, state, halt_ack, ref_mode, ref_ack);
      else n_pass++;
      n_checks++;
      if (stall_cnt !== es || flush_cnt !== ef || retired_cnt !== er) $display("FAIL rand_counters cyc %0d: %0d %0d %0d required %0d %0d %0d", n, stall_cnt, flush_cnt, retired_cnt, es, ef, er);
      else n_pass++;
    end
    halt_req = 1'b0;
    take_br = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    halt_req = 1'b0;
    take_br = 1'b0;
    ifid_r = '0; idex_r = '0; exmem_r = '0; memwb_r = '0;
    test_reset();
    test_adjacent_raw();
    test_zero_and_shift();
    test_taken_branch();
    test_halt_drain();
    test_reset_during_stall();
    test_retire_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Hazard and sequencing controller for the five-stage pipeline. It has no forwarding. It detects read-after-write hazards between the instruction in ID and older in-flight instructions, then stalls PC/IF-ID and injects bubbles into ID/EX. It flushes the three younger stages when a BEQ resolves taken in MEM. It also runs a debug halt/drain handshake and keeps wrapping performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- ifid_inst  in  32  instruction in IF/ID register (consumer)
- idex_inst  in  32  instruction in ID/EX
- exmem_inst  in  32  instruction in EX/MEM
- memwb_inst  in  32  instruction in MEM/WB
- branch_taken  in  1  EX/MEM holds BEQ and its comparison is equal
- halt_req  in  1  debug halt request, level
- halt_ack  out  1  pipeline drained and frozen
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  load 32'h0 into IF/ID
- idex_bubble  out  1  load 32'h0 into ID/EX
- exmem_flush  out  1  load 32'h0 into EX/MEM
- state  out  2  current FSM state (debug)
- stall_cnt, flush_cnt, retired_cnt  out  CNT_W each  performance counters

## Operation

**Register use decode.** A bubble is 32'h0, which decodes as no destination and no sources.
- Destination register:
  - R-type (op 000000): rd.
  - ADDI, ANDI, ORI, LW: rt.
  - SW, BEQ: none.
  - Register 0 is never a destination.
- Sources:
  - R-type non-shift: rs and rt.
  - SLL, SRL, SRA (func 000000/000010/000011): rt only.
  - ADDI, ANDI, ORI, LW: rs.
  - SW, BEQ: rs and rt.

**RAW hazard.** raw = any ifid source equals a destination of idex, exmem or memwb. The register file writes at the end of WB, so a MEM/WB producer still conflicts.

**Output priority:** reset > branch_taken > DRAIN/HALTED > raw.
- branch_taken:
  - ifid_flush=idex_bubble=exmem_flush=1.
  - pc_write=ifid_write=1, so the PC takes the target.
  - Applies in every state.
- DRAIN or HALTED, no branch: pc_write=ifid_write=0, idex_bubble=1. The IF/ID instruction is held, not lost.
- raw (RUN/STALL, no branch): pc_write=ifid_write=0, idex_bubble=1.
- Otherwise: pc_write=ifid_write=1, all flush/bubble outputs 0.

**FSM** (encoding RUN=0, STALL=1, DRAIN=2, HALTED=3):
- RUN:
  - halt_req → DRAIN.
  - else raw & !branch_taken → STALL.
- STALL:
  - halt_req → DRAIN.
  - else branch_taken or !raw → RUN.
- DRAIN:
  - !halt_req → RUN.
  - else idex, exmem, memwb all 32'h0 → HALTED.
- HALTED:
  - halt_ack=1.
  - !halt_req → RUN. The held IF/ID instruction is re-evaluated for raw in the same cycle.

**Counters** (wrap modulo 2^CNT_W):
- stall_cnt +1 per cycle with raw stalling (not in DRAIN/HALTED).
- flush_cnt +1 per branch_taken cycle.
- retired_cnt +1 per cycle with memwb_inst != 0.

## Timing
- Reset values:
  - state=RUN, all counters 0, halt_ack 0.
  - Pipeline outputs follow the combinational rules with state RUN.
- pc_write, ifid_write, ifid_flush, idex_bubble and exmem_flush are combinational from the inputs and state. They take effect at the same rising edge.
- halt_ack is a registered function of state, asserted the cycle after entering HALTED.
- Dependence distance gives the stall cycles:
  - distance 1 (adjacent): 3 stall cycles.
  - distance 2: 2.
  - distance 3: 1.
  - distance ≥4: 0.
- Boundary cases:
  - branch_taken during STALL removes the dependent instruction; the state returns to RUN.
  - branch_taken during DRAIN flushes IF/ID; the PC holds the target for resume.
  - halt_req dropped mid-DRAIN: return to RUN with no ack.
  - Async reset mid-STALL/DRAIN: state RUN immediately, counters cleared.

## Structure
- Package pipeline_pkg holds:
  - opcode constants (OP_ALUOP, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI);
  - shift func constants;
  - the 2-bit state enum.
- Sub-module reg_use_decode (inst → dest, dest_valid, rs_used, rt_used), instantiated four times.

## Test plan
- **Adjacent RAW.** add $1,$2,$3 then add $4,$1,$5 → stall 3 cycles, 3 ID/EX bubbles, stall_cnt=3, then consumer issues.
- **$0 and shift sources.**
  - ori $0,$0,5 then add $6,$0,$0 → no stall.
  - addi $7,$0,1 then sll $8,$9,2 (rs field=7) → no stall.
- **Taken branch.** Taken BEQ in EX/MEM → IF/ID, ID/EX, EX/MEM loaded 0 in one edge; flush_cnt=1; target fetched next.
- **Halt with long-latency load.** halt_req with LW in ID/EX → DRAIN for 3 cycles, HALTED, halt_ack=1; IF/ID unchanged. Release → RUN, fetch resumes; no instruction lost or duplicated.
- **Reset during stall.** reset asserted in STALL → state=RUN and counters=0 immediately, before the next clock edge.
- **Retirement count.** 10 non-nop instructions retired → retired_cnt=10; counter wrap at 2^CNT_W−1 → 0.
